// File: rtl/mrd_pkg.sv
// mrd_pkg: shared constants and types for the mixed-radix gather slice.
//   RDX5_N     - samples per radix-5 group
//   MRD_WIDTH  - default sample word width (1.17 signed)
//   MARGIN_MAX - saturation value of the redundant-sign-bit margin
//   cplx_t     - complex sample at the default width
//   margin_min - smaller of two 2-bit margins
package mrd_pkg;

    localparam int unsigned RDX5_N     = 5;
    localparam int unsigned MRD_WIDTH  = 18;
    localparam logic [1:0]  MARGIN_MAX = 2'd3;

    typedef struct packed {
        logic signed [MRD_WIDTH-1:0] re;
        logic signed [MRD_WIDTH-1:0] im;
    } cplx_t;

    function automatic logic [1:0] margin_min(input logic [1:0] a, input logic [1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/mrd_rdx5_gather_sign_margin.sv
// mrd_sign_margin: redundant-sign-bit count of one signed word.
//   word   in  WIDTH  two's complement sample
//   margin out 2      number of consecutive bits below the sign bit that
//                     equal the sign bit, saturated at MARGIN_MAX (3)
module mrd_sign_margin
    import mrd_pkg::*;
#(
    parameter int unsigned WIDTH = MRD_WIDTH
) (
    input  logic [WIDTH-1:0] word,
    output logic [1:0]       margin
);

    logic run;

    // Walk down from the bit just below the sign; stop at the first bit
    // that differs from the sign. Only three bits matter because of the cap.
    always_comb begin
        margin = '0;
        run    = 1'b1;
        for (int unsigned i = 1; i <= 32'(MARGIN_MAX); i++) begin
            if (run && (word[WIDTH-1-i] == word[WIDTH-1])) begin
                margin = 2'(i);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mrd_rdx5_gather.sv
// mrd_rdx5_gather: serial-to-parallel gather of radix-5 complex groups.
//   clk, rst          clock, synchronous active-high reset
//   in_val, in_sync   sample strobe, group restart (sample is index 0)
//   in_real, in_imag  serial signed sample
//   in_exp            block exponent, captured with the index-0 sample
//   out_val           one-cycle strobe, group presented on dout_*
//   dout_real/imag    gathered group, element k = k-th accepted sample
//   margin_out        min redundant-sign-bit count over the 10 words (cap 3)
//   exp_out           in_exp of the group's index-0 sample
// Build option: MRD_GATHER_MARGIN_EN compiles in margin detection; without
// it margin_out is tied to 0.
module mrd_rdx5_gather
    import mrd_pkg::*;
#(
    parameter int unsigned WIDTH = MRD_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_val,
    input  logic                    in_sync,
    input  logic signed [WIDTH-1:0] in_real,
    input  logic signed [WIDTH-1:0] in_imag,
    input  logic [3:0]              in_exp,
    output logic                    out_val,
    output logic signed [WIDTH-1:0] dout_real [0:RDX5_N-1],
    output logic signed [WIDTH-1:0] dout_imag [0:RDX5_N-1],
    output logic [1:0]              margin_out,
    output logic [3:0]              exp_out
);

    localparam logic [2:0] LAST_IDX = 3'(RDX5_N - 1);

    logic [2:0]              idx_q, idx_d, idx_cur;
    logic                    out_val_q, out_val_d;
    logic [3:0]              exp_fill_q, exp_fill_d;
    logic [3:0]              exp_out_q, exp_out_d;
    logic signed [WIDTH-1:0] fill_re_q [0:RDX5_N-2];
    logic signed [WIDTH-1:0] fill_re_d [0:RDX5_N-2];
    logic signed [WIDTH-1:0] fill_im_q [0:RDX5_N-2];
    logic signed [WIDTH-1:0] fill_im_d [0:RDX5_N-2];
    logic signed [WIDTH-1:0] dout_re_q [0:RDX5_N-1];
    logic signed [WIDTH-1:0] dout_re_d [0:RDX5_N-1];
    logic signed [WIDTH-1:0] dout_im_q [0:RDX5_N-1];
    logic signed [WIDTH-1:0] dout_im_d [0:RDX5_N-1];

`ifdef MRD_GATHER_MARGIN_EN
    logic [1:0] mg_re, mg_im, mg_pair;
    logic [1:0] run_mg_q, run_mg_d;
    logic [1:0] mg_out_q, mg_out_d;

    mrd_sign_margin #(.WIDTH(WIDTH)) u_mg_re (.word(in_real), .margin(mg_re));
    mrd_sign_margin #(.WIDTH(WIDTH)) u_mg_im (.word(in_imag), .margin(mg_im));

    assign mg_pair = margin_min(mg_re, mg_im);
`endif

    always_comb begin
        fill_re_d  = fill_re_q;
        fill_im_d  = fill_im_q;
        dout_re_d  = dout_re_q;
        dout_im_d  = dout_im_q;
        exp_fill_d = exp_fill_q;
        exp_out_d  = exp_out_q;
        out_val_d  = 1'b0;
`ifdef MRD_GATHER_MARGIN_EN
        run_mg_d   = run_mg_q;
        mg_out_d   = mg_out_q;
`endif
        // in_sync restarts the group before this cycle's sample is placed,
        // so a sync+val sample lands in slot 0 and the partial group is lost.
        idx_cur = in_sync ? '0 : idx_q;
        idx_d   = idx_cur;

        if (in_val) begin
            if (idx_cur == LAST_IDX) begin
                // Final sample bypasses the fill bank straight into the output
                // bank so the group appears one cycle after its last sample.
                for (int unsigned k = 0; k < RDX5_N - 1; k++) begin
                    dout_re_d[k] = fill_re_q[k];
                    dout_im_d[k] = fill_im_q[k];
                end
                dout_re_d[RDX5_N-1] = in_real;
                dout_im_d[RDX5_N-1] = in_imag;
                exp_out_d           = exp_fill_q;
                out_val_d           = 1'b1;
                idx_d               = '0;
`ifdef MRD_GATHER_MARGIN_EN
                mg_out_d            = margin_min(run_mg_q, mg_pair);
`endif
            end else begin
                fill_re_d[idx_cur[1:0]] = in_real;
                fill_im_d[idx_cur[1:0]] = in_imag;
                idx_d                   = idx_cur + 3'd1;
                if (idx_cur == 3'd0) begin
                    exp_fill_d = in_exp;
                end
`ifdef MRD_GATHER_MARGIN_EN
                run_mg_d = (idx_cur == 3'd0) ? margin_min(MARGIN_MAX, mg_pair)
                                             : margin_min(run_mg_q, mg_pair);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            out_val_q  <= 1'b0;
            exp_out_q  <= '0;
`ifdef MRD_GATHER_MARGIN_EN
            run_mg_q   <= MARGIN_MAX;
            mg_out_q   <= '0;
`endif
        end else begin
            idx_q      <= idx_d;
            out_val_q  <= out_val_d;
            exp_out_q  <= exp_out_d;
`ifdef MRD_GATHER_MARGIN_EN
            run_mg_q   <= run_mg_d;
            mg_out_q   <= mg_out_d;
`endif
        end
    end

    // Data banks carry no reset; they are only frozen while rst is high so a
    // group cut off by reset never disturbs the held output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fill_re_q  <= fill_re_d;
            fill_im_q  <= fill_im_d;
            dout_re_q  <= dout_re_d;
            dout_im_q  <= dout_im_d;
            exp_fill_q <= exp_fill_d;
        end
    end

    assign out_val   = out_val_q;
    assign dout_real = dout_re_q;
    assign dout_imag = dout_im_q;
    assign exp_out   = exp_out_q;
`ifdef MRD_GATHER_MARGIN_EN
    assign margin_out = mg_out_q;
`else
    assign margin_out = '0;
`endif

endmodule

// File: doc/mrd_rdx5_gather.md
MRD_RDX5_GATHER -- requirements
Module: mrd_rdx5_gather

Interface
REQ-001 Parameter WIDTH, default 18: sample word width, signed two's complement, 1.17 format.
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 in_val  in  1  serial sample strobe; one complex sample per cycle when high.
REQ-005 in_sync  in  1  group restart; the sample on this cycle (if in_val) is index 0.
REQ-006 in_real, in_imag  in  WIDTH each  serial sample, signed.
REQ-007 in_exp  in  4  block exponent, sampled with index-0 sample.
REQ-008 out_val  out  1  one-cycle strobe: parallel group valid.
REQ-009 dout_real[0:4], dout_imag[0:4]  out  WIDTH each  gathered group, index k = k-th accepted sample.
REQ-010 margin_out  out  2  min redundant-sign-bit count over the 10 group words, saturated at 3.
REQ-011 exp_out  out  4  in_exp captured with that group's index-0 sample.

Function
REQ-012 Index counter 0..4 SHALL advance only on in_val; cycles with in_val low hold all state.
REQ-013 Sample with in_val at index k SHALL be written to fill register slot k.
REQ-014 On the index-4 write, fill slots and the final sample SHALL transfer to the output registers on the same edge, with out_val high the following cycle only; counter wraps to 0.
REQ-015 Latency: out_val and dout SHALL be valid exactly 1 cycle after the index-4 sample's in_val cycle.
REQ-016 dout, margin_out, exp_out SHALL hold between out_val strobes (double-buffered; a new group may fill while the previous is held).
REQ-017 Back-to-back groups (25 consecutive in_val cycles) SHALL produce out_val every 5 cycles, no stall, no loss.
REQ-018 in_sync high SHALL force the counter to index 0 and discard any partial group; with in_val also high the sample is stored as index 0 (and in_exp captured).
REQ-019 in_sync with in_val low SHALL clear the counter only; no out_val.
REQ-020 Per-word margin: count of consecutive bits from WIDTH-2 downward equal to bit WIDTH-1, capped at 3 (e.g. 0x00001 -> 3, 0x1FFFF -> 0, 0x3C000 -> 3, 0x0C000 -> 1).
REQ-021 Running margin minimum SHALL reset to 3 at index 0 and be reduced per accepted word pair; margin_out = min including index-4 words.
REQ-022 Arithmetic: no rounding or scaling; samples pass bit-exact.

Reset
REQ-023 rst SHALL clear: counter=0, out_val=0, margin_out=0, exp_out=0, running margin=3; dout and fill registers are not reset.
REQ-024 rst mid-group SHALL discard the partial group; the first in_val after rst is index 0.
REQ-025 rst in the cycle out_val would rise SHALL suppress out_val.

Configuration
REQ-026 MRD_GATHER_MARGIN_EN defined: margin detection per REQ-020/021 compiled in.
REQ-027 MRD_GATHER_MARGIN_EN undefined: margin logic absent, margin_out constant 0 (downstream applies worst-case growth).

Structure
REQ-028 Shared package mrd_pkg SHALL hold RDX5_N=5, MRD_WIDTH=18, MARGIN_MAX=2'd3, and the complex-sample struct typedef.
REQ-029 One sub-module mrd_sign_margin (WIDTH-bit word -> 2-bit capped margin), instantiated 2x for the live sample pair.

Verification
REQ-030 Ramp 1..5 real, 0 imag, contiguous in_val -> out_val one cycle after 5th sample, dout_real={1,2,3,4,5}, margin_out=3.
REQ-031 Group containing real 0x1FFFF at index 2, others small -> margin_out=0; next group all 0x0C000 -> margin_out=1.
REQ-032 Samples with in_val gaps (pattern 1,0,1,1,0,0,1,1) -> single out_val, correct order, no extra strobe.
REQ-033 3 samples then in_sync+in_val with value 9, then 4 more -> one out_val, dout_real[0]=9, partial discarded; exp_out = in_exp at sync.
REQ-034 rst asserted after 4 samples, then 5 samples -> exactly one out_val, from post-reset samples only; out_val/margin_out/exp_out 0 during reset.
REQ-035 50 contiguous random samples, macro undefined -> 10 strobes, period 5, bit-exact data, margin_out=0 always.
